// File: rtl/axi_xbar.sv
// 1-master to 3-slave AXI4-Lite crossbar (SRAM / UART / CLINT) with registered requests,
// independent read and write paths, and an internal DECERR responder for unmapped addresses.
module axi_xbar #(
    parameter logic [31:0] S0_BASE = 32'h8000_0000,
    parameter logic [31:0] S0_MASK = 32'hF800_0000,
    parameter logic [31:0] S1_BASE = 32'hA000_03F8,
    parameter logic [31:0] S1_MASK = 32'hFFFF_FFF8,
    parameter logic [31:0] S2_BASE = 32'hA000_0048,
    parameter logic [31:0] S2_MASK = 32'hFFFF_FFF8
) (
    input  logic        clk,
    input  logic        rst,
    // master AR / R
    input  logic [31:0] m_araddr,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        m_rvalid,
    input  logic        m_rready,
    // master AW / W / B
    input  logic [31:0] m_awaddr,
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic [31:0] m_wdata,
    input  logic [7:0]  m_wstrb,
    input  logic        m_wvalid,
    output logic        m_wready,
    output logic [1:0]  m_bresp,
    output logic        m_bvalid,
    input  logic        m_bready,
    // slave side, address/data broadcast, handshakes one bit per slave
    output logic [31:0] s_araddr,
    output logic [31:0] s_awaddr,
    output logic [31:0] s_wdata,
    output logic [7:0]  s_wstrb,
    output logic [2:0]  s_arvalid,
    input  logic [2:0]  s_arready,
    output logic [2:0]  s_awvalid,
    input  logic [2:0]  s_awready,
    output logic [2:0]  s_wvalid,
    input  logic [2:0]  s_wready,
    input  logic [95:0] s_rdata,
    input  logic [5:0]  s_rresp,
    input  logic [2:0]  s_rvalid,
    output logic [2:0]  s_rready,
    input  logic [5:0]  s_bresp,
    input  logic [2:0]  s_bvalid,
    output logic [2:0]  s_bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_ERR} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_state_t;

    // Returns {hit, sel}; earlier slaves win where ranges overlap.
    function automatic logic [2:0] decode(input logic [31:0] addr);
        if ((addr & S0_MASK) == S0_BASE) return {1'b1, 2'd0};
        if ((addr & S1_MASK) == S1_BASE) return {1'b1, 2'd1};
        if ((addr & S2_MASK) == S2_BASE) return {1'b1, 2'd2};
        return 3'b000;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] sel);
        case (sel)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    r_state_t   r_state;
    logic [1:0] r_sel;
    w_state_t   w_state;
    logic [1:0] w_sel;
    logic       w_open;
    logic       aw_done;
    logic       w_done;

    logic [2:0] ar_dec;
    logic [2:0] aw_dec;
    logic       aw_hs;
    logic       w_hs;
    logic       w_accept;

    assign ar_dec   = decode(m_araddr);
    assign aw_dec   = decode(m_awaddr);
    assign aw_hs    = |(s_awvalid & s_awready);
    assign w_hs     = |(s_wvalid & s_wready);
    // AW and W are only ever taken together, so both readies share one condition.
    assign w_accept = w_open & m_awvalid & m_wvalid;
    assign m_awready = w_accept;
    assign m_wready  = w_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= R_IDLE;
            r_sel     <= 2'd0;
            m_arready <= 1'b0;
            s_arvalid <= 3'b000;
            s_araddr  <= 32'h0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    m_arready <= 1'b1;
                    if (m_arready && m_arvalid) begin
                        m_arready <= 1'b0;
                        s_araddr  <= m_araddr;
                        r_sel     <= ar_dec[1:0];
                        if (ar_dec[2]) begin
                            s_arvalid <= onehot(ar_dec[1:0]);
                            r_state   <= R_AR;
                        end else begin
                            r_state   <= R_ERR;
                        end
                    end
                end
                R_AR: begin
                    if (|(s_arvalid & s_arready)) begin
                        s_arvalid <= 3'b000;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (m_rvalid && m_rready) begin
                        m_arready <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                R_ERR: begin
                    if (m_rready) begin
                        m_arready <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;
        m_rresp  = 2'b00;
        s_rready = 3'b000;
        case (r_state)
            R_DATA: begin
                s_rready = onehot(r_sel) & {3{m_rready}};
                case (r_sel)
                    2'd0: begin
                        m_rvalid = s_rvalid[0];
                        m_rdata  = s_rdata[31:0];
                        m_rresp  = s_rresp[1:0];
                    end
                    2'd1: begin
                        m_rvalid = s_rvalid[1];
                        m_rdata  = s_rdata[63:32];
                        m_rresp  = s_rresp[3:2];
                    end
                    2'd2: begin
                        m_rvalid = s_rvalid[2];
                        m_rdata  = s_rdata[95:64];
                        m_rresp  = s_rresp[5:4];
                    end
                    default: begin
                        m_rvalid = 1'b0;
                    end
                endcase
            end
            R_ERR: begin
                m_rvalid = 1'b1;
                m_rresp  = 2'b11;
            end
            default: begin
                m_rvalid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state   <= W_IDLE;
            w_sel     <= 2'd0;
            w_open    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            s_awvalid <= 3'b000;
            s_wvalid  <= 3'b000;
            s_awaddr  <= 32'h0;
            s_wdata   <= 32'h0;
            s_wstrb   <= 8'h00;
        end else begin
            case (w_state)
                W_IDLE: begin
                    w_open <= 1'b1;
                    if (w_accept) begin
                        w_open   <= 1'b0;
                        s_awaddr <= m_awaddr;
                        s_wdata  <= m_wdata;
                        s_wstrb  <= m_wstrb;
                        w_sel    <= aw_dec[1:0];
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        if (aw_dec[2]) begin
                            s_awvalid <= onehot(aw_dec[1:0]);
                            s_wvalid  <= onehot(aw_dec[1:0]);
                            w_state   <= W_FWD;
                        end else begin
                            w_state   <= W_ERR;
                        end
                    end
                end
                W_FWD: begin
                    if (aw_hs) s_awvalid <= 3'b000;
                    if (w_hs)  s_wvalid  <= 3'b000;
                    // Either order, or both in one cycle, completes the forward phase.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        w_state <= W_RESP;
                    end else begin
                        aw_done <= aw_done | aw_hs;
                        w_done  <= w_done | w_hs;
                    end
                end
                W_RESP: begin
                    if (m_bvalid && m_bready) begin
                        w_open  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                W_ERR: begin
                    if (m_bready) begin
                        w_open  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
        s_bready = 3'b000;
        case (w_state)
            W_RESP: begin
                s_bready = onehot(w_sel) & {3{m_bready}};
                case (w_sel)
                    2'd0: begin
                        m_bvalid = s_bvalid[0];
                        m_bresp  = s_bresp[1:0];
                    end
                    2'd1: begin
                        m_bvalid = s_bvalid[1];
                        m_bresp  = s_bresp[3:2];
                    end
                    2'd2: begin
                        m_bvalid = s_bvalid[2];
                        m_bresp  = s_bresp[5:4];
                    end
                    default: begin
                        m_bvalid = 1'b0;
                    end
                endcase
            end
            W_ERR: begin
                m_bvalid = 1'b1;
                m_bresp  = 2'b11;
            end
            default: begin
                m_bvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_xbar.sv
// Directed bench for axi_xbar: drives the master and all three slave ports by hand.
module tb_axi_xbar;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] s_araddr;
    logic [31:0] s_awaddr;
    logic [31:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic [2:0]  s_arvalid;
    logic [2:0]  s_arready;
    logic [2:0]  s_awvalid;
    logic [2:0]  s_awready;
    logic [2:0]  s_wvalid;
    logic [2:0]  s_wready;
    logic [95:0] s_rdata;
    logic [5:0]  s_rresp;
    logic [2:0]  s_rvalid;
    logic [2:0]  s_rready;
    logic [5:0]  s_bresp;
    logic [2:0]  s_bvalid;
    logic [2:0]  s_bready;

    int checks   = 0;
    int failures = 0;

    int arv_cyc [3] = '{0, 0, 0};
    int aw_cnt  [3] = '{0, 0, 0};
    int w_cnt   [3] = '{0, 0, 0};
    int arv_snap [3];
    int aw_snap  [3];
    int w_snap   [3];

    always #5 clk = ~clk;

    axi_xbar dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    // Per-slave activity: cycles with arvalid high, completed AW and W handshakes.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (s_arvalid[i]) arv_cyc[i] <= arv_cyc[i] + 1;
            if (s_awvalid[i] && s_awready[i]) aw_cnt[i] <= aw_cnt[i] + 1;
            if (s_wvalid[i] && s_wready[i]) w_cnt[i] <= w_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 3; i++) begin
            arv_snap[i] = arv_cyc[i];
            aw_snap[i]  = aw_cnt[i];
            w_snap[i]   = w_cnt[i];
        end
    endtask

    initial begin
        rst = 1'b0;
        m_araddr = 32'h0; m_arvalid = 1'b0; m_rready = 1'b0;
        m_awaddr = 32'h0; m_awvalid = 1'b0; m_wdata = 32'h0; m_wstrb = 8'h00;
        m_wvalid = 1'b0; m_bready = 1'b0;
        s_arready = 3'b000; s_awready = 3'b000; s_wready = 3'b000;
        s_rdata = 96'h0; s_rresp = 6'b0; s_rvalid = 3'b000;
        s_bresp = 6'b0; s_bvalid = 3'b000;

        // reset state
        tick(); tick();
        chk("rst_arready", {31'b0, m_arready}, 32'd0);
        chk("rst_awready", {31'b0, m_awready}, 32'd0);
        chk("rst_valids", {26'b0, s_arvalid, s_awvalid}, 32'd0);
        chk("rst_mvalids", {30'b0, m_rvalid, m_bvalid}, 32'd0);
        chk("rst_addr", s_araddr | s_awaddr | s_wdata, 32'd0);
        rst = 1'b1;
        tick(); tick();
        chk("post_rst_arready", {31'b0, m_arready}, 32'd1);

        // 1: read SRAM, zero-wait slave
        snap();
        m_araddr = 32'h8000_0010; m_arvalid = 1'b1; #1;
        tick();
        m_arvalid = 1'b0; #1;
        chk("t1_s_arvalid", {29'b0, s_arvalid}, 32'b001);
        chk("t1_s_araddr", s_araddr, 32'h8000_0010);
        chk("t1_arready_busy", {31'b0, m_arready}, 32'd0);
        s_arready = 3'b001;
        tick();
        s_arready = 3'b000;
        s_rdata = {32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF};
        s_rresp = 6'b01_10_00; s_rvalid = 3'b111; m_rready = 1'b0; #1;
        chk("t1_rvalid", {31'b0, m_rvalid}, 32'd1);
        chk("t1_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("t1_rresp", {30'b0, m_rresp}, 32'd0);
        chk("t1_rready_hold", {29'b0, s_rready}, 32'b000);
        m_rready = 1'b1; #1;
        chk("t1_rready", {29'b0, s_rready}, 32'b001);
        tick();
        s_rvalid = 3'b000; m_rready = 1'b0; #1;
        chk("t1_rvalid_done", {31'b0, m_rvalid}, 32'd0);
        chk("t1_arready_back", {31'b0, m_arready}, 32'd1);
        chk("t1_arv_s0", arv_cyc[0] - arv_snap[0], 32'd1);
        chk("t1_arv_s12", (arv_cyc[1] - arv_snap[1]) + (arv_cyc[2] - arv_snap[2]), 32'd0);

        // 2: write UART, AW accepted before W
        snap();
        m_awaddr = 32'hA000_03F8; m_wdata = 32'h41; m_wstrb = 8'h01;
        m_awvalid = 1'b1; m_wvalid = 1'b1; #1;
        chk("t2_awready", {30'b0, m_awready, m_wready}, 32'b11);
        tick();
        m_awvalid = 1'b0; m_wvalid = 1'b0; #1;
        chk("t2_fwd", {26'b0, s_awvalid, s_wvalid}, {26'b0, 3'b010, 3'b010});
        chk("t2_addr", s_awaddr, 32'hA000_03F8);
        chk("t2_data", {s_wstrb, s_wdata[23:0]}, {8'h01, 24'h41});
        s_awready = 3'b010;
        tick();
        s_awready = 3'b000; #1;
        chk("t2_aw_dropped", {26'b0, s_awvalid, s_wvalid}, {26'b0, 3'b000, 3'b010});
        s_wready = 3'b010;
        tick();
        s_wready = 3'b000;
        s_bresp = 6'b00_00_10; s_bvalid = 3'b010; m_bready = 1'b1; #1;
        chk("t2_w_dropped", {29'b0, s_wvalid}, 32'b000);
        chk("t2_bvalid", {31'b0, m_bvalid}, 32'd1);
        chk("t2_bresp", {30'b0, m_bresp}, 32'd0);
        chk("t2_bready", {29'b0, s_bready}, 32'b010);
        tick();
        s_bvalid = 3'b000; m_bready = 1'b0; #1;
        chk("t2_bvalid_done", {31'b0, m_bvalid}, 32'd0);
        chk("t2_aw_hs", aw_cnt[1] - aw_snap[1], 32'd1);
        chk("t2_w_hs", w_cnt[1] - w_snap[1], 32'd1);

        // 3: unmapped read and write get DECERR
        snap();
        m_araddr = 32'h0000_1000; m_arvalid = 1'b1; #1;
        tick();
        m_arvalid = 1'b0; #1;
        chk("t3_r_noarvalid", {29'b0, s_arvalid}, 32'b000);
        chk("t3_r_err", {m_rdata[29:0], m_rresp}, {30'b0, 2'b11});
        chk("t3_r_valid", {31'b0, m_rvalid}, 32'd1);
        m_rready = 1'b1;
        tick();
        m_rready = 1'b0; #1;
        chk("t3_r_done", {31'b0, m_rvalid}, 32'd0);
        chk("t3_arv_none", arv_cyc[0] + arv_cyc[1] + arv_cyc[2]
            - arv_snap[0] - arv_snap[1] - arv_snap[2], 32'd0);
        m_awaddr = 32'h0000_1000; m_awvalid = 1'b1; m_wvalid = 1'b1; #1;
        tick();
        m_awvalid = 1'b0; m_wvalid = 1'b0; #1;
        chk("t3_w_nofwd", {26'b0, s_awvalid, s_wvalid}, 32'd0);
        chk("t3_b_err", {30'b0, m_bresp}, 32'b11);
        chk("t3_b_valid", {31'b0, m_bvalid}, 32'd1);
        m_bready = 1'b1;
        tick();
        m_bready = 1'b0; #1;
        chk("t3_b_done", {31'b0, m_bvalid}, 32'd0);

        // 4: AW waits for W
        m_awaddr = 32'hA000_0048; m_wdata = 32'h5; m_wstrb = 8'h0F;
        m_awvalid = 1'b1; m_wvalid = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_awready_wait", {30'b0, m_awready, m_wready}, 32'd0);
            tick();
        end
        chk("t4_no_fwd", {29'b0, s_awvalid}, 32'd0);
        m_wvalid = 1'b1; #1;
        chk("t4_accept", {30'b0, m_awready, m_wready}, 32'b11);
        tick();
        chk("t4_one_cycle", {30'b0, m_awready, m_wready}, 32'd0);
        m_awvalid = 1'b0; m_wvalid = 1'b0; #1;
        chk("t4_fwd_s2", {26'b0, s_awvalid, s_wvalid}, {26'b0, 3'b100, 3'b100});
        s_awready = 3'b100; s_wready = 3'b100;
        tick();
        s_awready = 3'b000; s_wready = 3'b000;
        s_bresp = 6'b00_11_11; s_bvalid = 3'b100; m_bready = 1'b1; #1;
        chk("t4_both_dropped", {26'b0, s_awvalid, s_wvalid}, 32'd0);
        chk("t4_b", {29'b0, m_bvalid, m_bresp}, {29'b0, 1'b1, 2'b00});
        tick();
        s_bvalid = 3'b000; m_bready = 1'b0; #1;

        // 5: concurrent read CLINT and write SRAM with delayed B
        m_araddr = 32'hA000_0048; m_arvalid = 1'b1;
        m_awaddr = 32'h8000_0000; m_wdata = 32'h77; m_wstrb = 8'hFF;
        m_awvalid = 1'b1; m_wvalid = 1'b1; #1;
        chk("t5_accept", {29'b0, m_arready, m_awready, m_wready}, 32'b111);
        tick();
        m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0; #1;
        chk("t5_fwd", {26'b0, s_arvalid, s_awvalid}, {26'b0, 3'b100, 3'b001});
        s_arready = 3'b100; s_awready = 3'b001; s_wready = 3'b001;
        tick();
        s_arready = 3'b000; s_awready = 3'b000; s_wready = 3'b000;
        s_rdata = {32'h1234_5678, 32'h0, 32'hFFFF_FFFF}; s_rresp = 6'b00_00_11;
        s_rvalid = 3'b100; m_rready = 1'b1; m_bready = 1'b1; #1;
        chk("t5_rdata", m_rdata, 32'h1234_5678);
        chk("t5_r", {28'b0, m_rvalid, m_rresp, m_bvalid}, {28'b0, 1'b1, 2'b00, 1'b0});
        tick();
        s_rvalid = 3'b000; m_rready = 1'b0; #1;
        chk("t5_r_done", {30'b0, m_rvalid, m_arready}, 32'b01);
        for (int i = 0; i < 9; i++) tick();
        chk("t5_b_pending", {31'b0, m_bvalid}, 32'd0);
        s_bresp = 6'b11_00_01; s_bvalid = 3'b001; #1;
        chk("t5_b", {29'b0, m_bvalid, m_bresp}, {29'b0, 1'b1, 2'b01});
        tick();
        s_bvalid = 3'b000; m_bready = 1'b0; #1;
        chk("t5_b_done", {31'b0, m_bvalid}, 32'd0);

        // 6: reset in R_DATA, then a normal read
        m_araddr = 32'h8000_0000; m_arvalid = 1'b1; #1;
        tick();
        m_arvalid = 1'b0; s_arready = 3'b001;
        tick();
        s_arready = 3'b000; s_rdata = {64'h0, 32'hAAAA_5555}; s_rresp = 6'b0;
        s_rvalid = 3'b001; m_rready = 1'b0; #1;
        chk("t6_rvalid_pre", {31'b0, m_rvalid}, 32'd1);
        rst = 1'b0; #1;
        chk("t6_rst_valids", {25'b0, m_rvalid, s_arvalid, s_awvalid}, 32'd0);
        chk("t6_rst_ready", {29'b0, m_arready, m_awready, m_bvalid}, 32'd0);
        chk("t6_rst_addr", s_araddr, 32'd0);
        s_rvalid = 3'b000;
        tick();
        rst = 1'b1;
        tick(); tick();
        chk("t6_no_resp", {30'b0, m_rvalid, m_arready}, 32'b01);
        m_araddr = 32'h8000_0000; m_arvalid = 1'b1; #1;
        tick();
        m_arvalid = 1'b0; #1;
        chk("t6_arvalid", {29'b0, s_arvalid}, 32'b001);
        s_arready = 3'b001;
        tick();
        s_arready = 3'b000; s_rdata = {64'h0, 32'hCAFE_F00D}; s_rvalid = 3'b001;
        m_rready = 1'b1; #1;
        chk("t6_rdata", m_rdata, 32'hCAFE_F00D);
        chk("t6_rvalid", {31'b0, m_rvalid}, 32'd1);
        tick();
        s_rvalid = 3'b000; m_rready = 1'b0; #1;
        chk("t6_done", {30'b0, m_rvalid, m_arready}, 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
